// File: rtl/mul_acc.sv
// mul_acc: sequential unsigned multiply-accumulate, y = q*x + r.
// Rebuilds a dividend from the divider's quotient/divisor/remainder using
// radix-2 shift-add over a fixed 32 iterations (no early exit).
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   en    - start; loads q/x/r and (re)starts, overriding any job in flight
//   q     - 32-bit multiplier (quotient)
//   x     - 32-bit multiplicand (divisor)
//   r     - 32-bit addend (remainder)
//   y     - 64-bit registered result, updated only when done pulses
//   busy  - high while a job is in flight
//   done  - one-cycle pulse in the cycle y takes a new result
module mul_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] q,
  input  logic [31:0] x,
  input  logic [31:0] r,
  output logic [63:0] y,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  typedef struct packed {
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [4:0]  cnt;
  } dp_t;

  state_t      state, state_n;
  dp_t         dp, dp_n;
  logic [63:0] y_n;
  logic        busy_n, done_n;

  // State and datapath registers. Reset abandons any job outright, so no
  // done pulse can follow a mid-computation reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dp    <= '0;
      y     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      dp    <= dp_n;
      y     <= y_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    dp_n    = dp;
    y_n     = y;
    busy_n  = busy;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
      end
      RUN: begin
        // Full 64-bit add; max q*x+r = 2^64-2^32 so it cannot overflow.
        if (dp.mplier[0])
          dp_n.acc = dp.acc + dp.mcand;
        dp_n.mcand  = {dp.mcand[62:0], 1'b0};
        dp_n.mplier = {1'b0, dp.mplier[31:1]};
        dp_n.cnt    = dp.cnt + 5'd1;
        if (dp.cnt == 5'd31)
          state_n = FIN;
      end
      FIN: begin
        y_n     = dp.acc;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase

    // A start wins over whatever the FSM was doing; a discarded job never
    // reaches FIN, so it cannot produce a done pulse or touch y.
    if (en) begin
      dp_n.acc    = {32'b0, r};
      dp_n.mcand  = {32'b0, x};
      dp_n.mplier = q;
      dp_n.cnt    = 5'd0;
      state_n     = RUN;
      busy_n      = 1'b1;
      done_n      = 1'b0;
      y_n         = y;
    end
  end

endmodule

// File: tb/tb_mul_acc.sv
module tb_mul_acc;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] q, x, r;
  logic [63:0] y;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  mul_acc dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .q    (q),
    .x    (x),
    .r    (r),
    .y    (y),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    return 64'(a) * 64'(b) + 64'(c);
  endfunction

  // Called at a negedge: presents a one-cycle en pulse (edge E0), returns at
  // the negedge after E0 with en low and the operand inputs scrambled.
  task automatic start(input logic [31:0] qa, input logic [31:0] xa, input logic [31:0] ra);
    en = 1'b1; q = qa; x = xa; r = ra;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0; q = $urandom; x = $urandom; r = $urandom;
  endtask

  // Called at the negedge after E0. lat = edges from E0 to first done sample
  // (-1 on timeout); bcnt = busy samples before done; ychg = y moved early.
  task automatic wait_done(output int lat, output int bcnt, output bit ychg);
    logic [63:0] y0;
    y0 = y; lat = -1; bcnt = 0; ychg = 1'b0;
    if (busy) bcnt++;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin lat = i; break; end
      if (busy) bcnt++;
      if (y !== y0) ychg = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; q = '0; x = '0; r = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({y, busy, done} !== 66'd0) begin
      errors++; $display("FAIL reset_state y=%h busy=%b done=%b exp 0/0/0", y, busy, done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({y, busy, done} !== 66'd0) begin
      errors++; $display("FAIL idle_after_reset y=%h busy=%b done=%b exp 0/0/0", y, busy, done);
    end
  endtask

  task automatic test_basic;
    int lat, bc; bit yc;
    start(32'd7, 32'd6, 32'd3);
    wait_done(lat, bc, yc);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL basic_latency got %0d exp 33", lat); end
    checks++;
    if (y !== 64'd45) begin errors++; $display("FAIL basic_y got %0d exp 45", y); end
    checks++;
    if (bc !== 33) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 33", bc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b exp 0", busy); end
    checks++;
    if (yc) begin errors++; $display("FAIL basic_y_early_change got 1 exp 0"); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || y !== 64'd45) begin
      errors++; $display("FAIL basic_done_width done=%b y=%0d exp 0/45", done, y);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (y !== 64'd45) begin errors++; $display("FAIL basic_y_hold got %0d exp 45", y); end
  endtask

  task automatic test_extremes;
    int lat, bc; bit yc;
    start('1, '1, '1);
    wait_done(lat, bc, yc);
    checks++;
    if (y !== 64'hFFFFFFFF_00000000 || lat !== 33) begin
      errors++; $display("FAIL ext_max y=%h lat=%0d exp ffffffff00000000/33", y, lat);
    end
    @(negedge clk);
    start(32'd0, 32'h12345678, 32'd5);
    wait_done(lat, bc, yc);
    checks++;
    if (y !== 64'd5 || lat !== 33) begin
      errors++; $display("FAIL ext_q0 y=%0d lat=%0d exp 5/33", y, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int lat, bc; bit yc;
    logic [31:0] qa, xa, ra;
    for (int i = 0; i < 40; i++) begin
      qa = $urandom; xa = $urandom; ra = $urandom;
      if (i % 4 == 1) qa = '1;
      if (i % 4 == 2) xa = 32'h8000_0000;
      start(qa, xa, ra);
      wait_done(lat, bc, yc);
      checks++;
      if (y !== model(qa, xa, ra) || lat !== 33) begin
        errors++;
        $display("FAIL random q=%h x=%h r=%h y=%h lat=%0d exp %h/33", qa, xa, ra, y, lat,
                 model(qa, xa, ra));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_trip;
    int lat, bc; bit yc;
    logic [31:0] d, xa;
    start(32'd142, 32'd7, 32'd6);
    wait_done(lat, bc, yc);
    checks++;
    if (y !== 64'd1000) begin errors++; $display("FAIL roundtrip_1000 got %0d exp 1000", y); end
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      d  = $urandom;
      xa = (i % 2) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (xa == 0) xa = 32'd1;
      start(d / xa, xa, d % xa);
      wait_done(lat, bc, yc);
      checks++;
      if (y !== {32'b0, d} || lat !== 33) begin
        errors++; $display("FAIL roundtrip d=%h x=%h y=%h lat=%0d", d, xa, y, lat);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_restart;
    int lat, bc, extra; bit yc, early;
    early = 1'b0;
    start(32'd3, 32'd3, 32'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done) early = 1'b1;
    end
    start(32'd10, 32'd10, 32'd1);
    wait_done(lat, bc, yc);
    checks++;
    if (early || lat !== 33) begin
      errors++; $display("FAIL restart_latency lat=%0d early=%b exp 33/0", lat, early);
    end
    checks++;
    if (y !== 64'd101) begin errors++; $display("FAIL restart_y got %0d exp 101", y); end
    extra = 0;
    repeat (40) begin @(negedge clk); if (done) extra++; end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL restart_single_done extra=%0d exp 0", extra); end
    // Restart while in the final cycle before the result lands.
    start(32'd5, 32'd5, 32'd0);
    repeat (31) @(negedge clk);
    start(32'd4, 32'd4, 32'd4);
    wait_done(lat, bc, yc);
    checks++;
    if (lat !== 33 || y !== 64'd20 || yc) begin
      errors++; $display("FAIL restart_late lat=%0d y=%0d ychg=%b exp 33/20/0", lat, y, yc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    int cnt;
    start(32'd11, 32'd13, 32'd2);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({y, busy, done} !== 66'd0) begin
      errors++; $display("FAIL midop_reset y=%h busy=%b done=%b exp 0/0/0", y, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (50) begin @(negedge clk); if (done || busy) cnt++; end
    checks++;
    if (cnt !== 0 || y !== 64'd0) begin
      errors++; $display("FAIL midop_no_done activity=%0d y=%h exp 0/0", cnt, y);
    end
  endtask

  task automatic test_held_en;
    int lat, bc; bit yc, bad;
    bad = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin q = $urandom; x = $urandom; r = $urandom; end
      else begin q = 32'd2; x = 32'd9; r = 32'd4; end
      @(posedge clk);
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
    end
    en = 1'b0; q = $urandom; x = $urandom; r = $urandom;
    checks++;
    if (bad) begin errors++; $display("FAIL held_en_flags busy/done wrong while en held"); end
    wait_done(lat, bc, yc);
    checks++;
    if (lat !== 33 || y !== 64'd22) begin
      errors++; $display("FAIL held_en lat=%0d y=%0d exp 33/22", lat, y);
    end
  endtask

  // Entered in a done cycle: each new start lands on the edge that ends done.
  task automatic test_back_to_back;
    int lat, bc; bit yc;
    logic [31:0] qa, xa, ra;
    for (int i = 0; i < 4; i++) begin
      qa = $urandom; xa = $urandom; ra = $urandom;
      start(qa, xa, ra);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL b2b_start done=%b busy=%b exp 0/1", done, busy);
      end
      wait_done(lat, bc, yc);
      checks++;
      if (lat !== 33 || y !== model(qa, xa, ra)) begin
        errors++; $display("FAIL b2b lat=%0d y=%h exp 33/%h", lat, y, model(qa, xa, ra));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_random();
    test_round_trip();
    test_restart();
    test_reset_midop();
    test_held_en();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
